// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor.
//
// A table of 2^IDX_BITS saturating counters (the PHT) is looked up in
// Decode, combinationally, and trained from Execute. The global history
// register (GHR) shifts in each prediction speculatively. When a
// mispredict resolves, it is rebuilt from the snapshot the branch carried
// down the pipe.
//
// Optional feature: define GSHARE_PRED_STATS_EN to add the branch and
// mispredict statistics counters (stat_branches, stat_mispredicts).
//
// Handshake: predict_en and resolve_en are single-cycle valid strobes.
// There is no ready, and the predictor accepts every strobe in the cycle
// it is asserted. Every other input is sampled only while its strobe is
// high, so resolve_mispredict, resolve_taken, resolve_index and
// resolve_ghr mean nothing while resolve_en is low.
module gshare_predictor #(
    parameter int IDX_BITS   = 8,  // log2 of PHT entries
    parameter int GHR_BITS   = 8,  // history length, 1..IDX_BITS
    parameter int CTR_BITS   = 2,  // saturating counter width
    parameter int INDEX_MODE = 1   // 0 bimodal, 1 gshare, 2 global-only
) (
    input  logic                clk,
    input  logic                rst,
    // Decode-side lookup
    input  logic                predict_en,
    input  logic [31:0]         pc_d,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_index,
    output logic [GHR_BITS-1:0] pred_ghr,
    // Execute-side resolve
    input  logic                resolve_en,
    input  logic [IDX_BITS-1:0] resolve_index,
    input  logic [GHR_BITS-1:0] resolve_ghr,
    input  logic                resolve_taken,
    input  logic                resolve_mispredict,
    // Current speculative history
    output logic [GHR_BITS-1:0] ghr
`ifdef GSHARE_PRED_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int PHT_SIZE = 1 << IDX_BITS;

    // A reset counter sits just below the taken threshold (weakly not-taken).
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (GHR_BITS < 1 || GHR_BITS > IDX_BITS) begin : gBadGhrBits
        $error("gshare_predictor: GHR_BITS must be in 1..IDX_BITS");
    end
    if (CTR_BITS < 1) begin : gBadCtrBits
        $error("gshare_predictor: CTR_BITS must be at least 1");
    end
    if (INDEX_MODE < 0 || INDEX_MODE > 2) begin : gBadIndexMode
        $error("gshare_predictor: INDEX_MODE must be 0, 1 or 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTR_BITS-1:0] pht [PHT_SIZE];
    logic [GHR_BITS-1:0] ghrQ;

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] pcIdx;
    logic [IDX_BITS-1:0] histExt;
    logic [IDX_BITS-1:0] lookupIdx;
    logic [CTR_BITS-1:0] lookupCtr;

    // Only the word-aligned PC bits that form the index are used.
    logic unusedPcBits;
    assign unusedPcBits = ^{pc_d[31:IDX_BITS+2], pc_d[1:0]};

    // Form the PHT index from the PC and the zero-extended history.
    always_comb begin
        pcIdx   = pc_d[IDX_BITS+1:2];
        histExt = '0;
        histExt[GHR_BITS-1:0] = ghrQ;
        case (INDEX_MODE)
            0:       lookupIdx = pcIdx;
            2:       lookupIdx = histExt;
            default: lookupIdx = pcIdx ^ histExt;
        endcase
    end

    // Zero-latency read. A same-cycle update to this entry is not bypassed,
    // so the lookup always sees the value held before this edge.
    assign lookupCtr  = pht[lookupIdx];
    assign pred_taken = lookupCtr[CTR_BITS-1];
    assign pred_index = lookupIdx;
    assign pred_ghr   = ghrQ;
    assign ghr        = ghrQ;

    // ------------------------------------------------------------------
    // History next-value candidates
    // ------------------------------------------------------------------
    logic [GHR_BITS-1:0] specShift;     // history after this prediction
    logic [GHR_BITS-1:0] recoverShift;  // history rebuilt after a mispredict

    if (GHR_BITS == 1) begin : gHistOne
        // A single-bit history simply holds the most recent outcome.
        logic unusedResolveGhr;
        assign unusedResolveGhr = resolve_ghr[0];
        assign specShift    = pred_taken;
        assign recoverShift = resolve_taken;
    end else begin : gHistMulti
        // The oldest bit falls off the top when a new outcome enters.
        logic unusedResolveMsb;
        assign unusedResolveMsb = resolve_ghr[GHR_BITS-1];
        assign specShift    = {ghrQ[GHR_BITS-2:0], pred_taken};
        assign recoverShift = {resolve_ghr[GHR_BITS-2:0], resolve_taken};
    end

    logic recoverFire;
    assign recoverFire = resolve_en & resolve_mispredict;

    // Speculative history register. Recovery wins over a simultaneous
    // prediction, because that younger Decode instruction is being flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghrQ <= '0;
        end else if (recoverFire) begin
            ghrQ <= recoverShift;
        end else if (predict_en) begin
            ghrQ <= specShift;
        end
    end

    // ------------------------------------------------------------------
    // PHT training
    // ------------------------------------------------------------------
    logic [CTR_BITS-1:0] resolveCtr;
    logic [CTR_BITS-1:0] resolveCtrNext;

    // Saturating step of the resolved entry toward the actual direction.
    always_comb begin
        resolveCtr     = pht[resolve_index];
        resolveCtrNext = resolveCtr;
        if (resolve_taken) begin
            if (resolveCtr != CTR_MAX) begin
                resolveCtrNext = resolveCtr + 1'b1;
            end
        end else begin
            if (resolveCtr != CTR_MIN) begin
                resolveCtrNext = resolveCtr - 1'b1;
            end
        end
    end

    // Counter table. Every resolved branch trains its entry, whether or not
    // it was mispredicted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (resolve_en) begin
            pht[resolve_index] <= resolveCtrNext;
        end
    end

`ifdef GSHARE_PRED_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [31:0] statBranchesQ;
    logic [31:0] statMispredictsQ;

    // Free-running resolve and mispredict counters. They wrap modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            statBranchesQ    <= '0;
            statMispredictsQ <= '0;
        end else begin
            if (resolve_en) begin
                statBranchesQ <= statBranchesQ + 32'd1;
            end
            if (recoverFire) begin
                statMispredictsQ <= statMispredictsQ + 32'd1;
            end
        end
    end

    assign stat_branches    = statBranchesQ;
    assign stat_mispredicts = statMispredictsQ;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor with the default configuration (gshare,
// 8-bit index, 8-bit history, 2-bit counters). Directed scenarios first,
// then randomized traffic. A behavioural model built on integer arrays
// drives every expected value. Define GSHARE_PRED_STATS_EN to include the
// statistics outputs.
module tb_gshare_predictor;

    localparam int IDX_BITS = 8;
    localparam int GHR_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int PHT_SIZE = 256;

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic                clk = 1'b0;
    logic                rst;
    logic                predict_en;
    logic [31:0]         pc_d;
    logic                pred_taken;
    logic [IDX_BITS-1:0] pred_index;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                resolve_en;
    logic [IDX_BITS-1:0] resolve_index;
    logic [GHR_BITS-1:0] resolve_ghr;
    logic                resolve_taken;
    logic                resolve_mispredict;
    logic [GHR_BITS-1:0] ghr;
`ifdef GSHARE_PRED_STATS_EN
    logic [31:0]         statBranches;
    logic [31:0]         statMispredicts;
`endif

    always #5 clk = ~clk;

    gshare_predictor #(
        .IDX_BITS  (IDX_BITS),
        .GHR_BITS  (GHR_BITS),
        .CTR_BITS  (CTR_BITS),
        .INDEX_MODE(1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .predict_en        (predict_en),
        .pc_d              (pc_d),
        .pred_taken        (pred_taken),
        .pred_index        (pred_index),
        .pred_ghr          (pred_ghr),
        .resolve_en        (resolve_en),
        .resolve_index     (resolve_index),
        .resolve_ghr       (resolve_ghr),
        .resolve_taken     (resolve_taken),
        .resolve_mispredict(resolve_mispredict),
        .ghr               (ghr)
`ifdef GSHARE_PRED_STATS_EN
        ,
        .stat_branches     (statBranches),
        .stat_mispredicts  (statMispredicts)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    int          phtModel [PHT_SIZE];
    int          ghrModel;
    int          statBModel;
    int          statMModel;
    logic [31:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int modelIndex(input logic [31:0] pc);
        return ((pc >> 2) & 255) ^ ghrModel;
    endfunction

    // PC whose gshare index lands on idx under the current model history.
    function automatic logic [31:0] pcFor(input int idx);
        return 32'h0040_0000 | 32'((idx ^ ghrModel) << 2);
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------

    // Present a lookup with no strobes, then let the combinational outputs settle.
    task automatic peek(input logic [31:0] pc);
        predict_en = 1'b0;
        resolve_en = 1'b0;
        rst        = 1'b0;
        pc_d       = pc;
        #1;
    endtask

    // One full cycle: drive inputs, check the lookup against the model,
    // clock, advance the model, and check the new history (and statistics).
    task automatic stepCycle(input logic r, input logic pe, input logic [31:0] pc,
                             input logic re, input int ridx, input int rghr,
                             input logic rt, input logic rm);
        int   idx;
        logic tk;
        rst                = r;
        predict_en         = pe;
        pc_d               = pc;
        resolve_en         = re;
        resolve_index      = 8'(ridx);
        resolve_ghr        = 8'(rghr);
        resolve_taken      = rt;
        resolve_mispredict = rm;
        #1;
        idx = modelIndex(pc);
        tk  = (phtModel[idx] >= 2);
        if (!r) begin
            checkVal("pred_index", 32'(pred_index), 32'(idx));
            checkVal("pred_taken", 32'(pred_taken), 32'(tk));
            checkVal("pred_ghr", 32'(pred_ghr), 32'(ghrModel));
        end
        @(posedge clk);
        if (r) begin
            ghrModel   = 0;
            statBModel = 0;
            statMModel = 0;
            for (int i = 0; i < PHT_SIZE; i++) phtModel[i] = 1;
        end else begin
            if (re && rm)  ghrModel = ((rghr << 1) | int'(rt)) & 255;
            else if (pe)   ghrModel = ((ghrModel << 1) | int'(tk)) & 255;
            if (re) begin
                if (rt) phtModel[ridx & 255] = (phtModel[ridx & 255] == 3) ? 3 : phtModel[ridx & 255] + 1;
                else    phtModel[ridx & 255] = (phtModel[ridx & 255] == 0) ? 0 : phtModel[ridx & 255] - 1;
                statBModel++;
                if (rm) statMModel++;
            end
        end
        exp_q.push_back(32'(ghrModel));
        #1;
        checkVal("ghr", 32'(ghr), exp_q.pop_front());
`ifdef GSHARE_PRED_STATS_EN
        checkVal("stat_branches", statBranches, 32'(statBModel));
        checkVal("stat_mispredicts", statMispredicts, 32'(statMModel));
`endif
        @(negedge clk);
    endtask

    // Resolve-only cycle: no prediction, lookup parked at PC 0x00400010.
    task automatic resolveOnly(input int ridx, input int rghr, input logic rt, input logic rm);
        stepCycle(1'b0, 1'b0, 32'h0040_0010, 1'b1, ridx, rghr, rt, rm);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; predict_en = 1'b0; pc_d = '0; resolve_en = 1'b0;
        resolve_index = '0; resolve_ghr = '0; resolve_taken = 1'b0; resolve_mispredict = 1'b0;
        ghrModel = 0; statBModel = 0; statMModel = 0;
        @(negedge clk);

        // Reset, then lookup at 0x00400010.
        stepCycle(1'b1, 1'b0, 32'h0040_0010, 1'b0, 0, 0, 1'b0, 1'b0);
        peek(32'h0040_0010);
        checkVal("reset_ghr", 32'(ghr), 32'h00);
        checkVal("reset_index", 32'(pred_index), 32'h04);
        checkVal("reset_taken", 32'(pred_taken), 32'h0);

        // Training entry 4 twice: 1 -> 2 -> 3.
        resolveOnly(4, 0, 1'b1, 1'b0);
        resolveOnly(4, 0, 1'b1, 1'b0);
        peek(32'h0040_0010);
        checkVal("trained_taken", 32'(pred_taken), 32'h1);

        // Speculative shifts: taken (index 4), then not taken (index 5), then hold.
        stepCycle(1'b0, 1'b1, 32'h0040_0010, 1'b0, 0, 0, 1'b0, 1'b0);
        checkVal("shift_taken", 32'(ghr), 32'h01);
        stepCycle(1'b0, 1'b1, 32'h0040_0010, 1'b0, 0, 0, 1'b0, 1'b0);
        checkVal("shift_not_taken", 32'(ghr), 32'h02);
        stepCycle(1'b0, 1'b0, 32'h0040_0010, 1'b0, 0, 0, 1'b0, 1'b0);
        checkVal("hold", 32'(ghr), 32'h02);

        // A mispredict recovery loads 0xF3, then recovery beats predict_en.
        resolveOnly(20, 8'h79, 1'b1, 1'b1);
        checkVal("recover_load", 32'(ghr), 32'hF3);
        stepCycle(1'b0, 1'b1, 32'h0040_0010, 1'b1, 21, 8'h05, 1'b1, 1'b1);
        checkVal("recover_priority", 32'(ghr), 32'h0B);

        // resolve_mispredict ignored when resolve_en is low.
        stepCycle(1'b0, 1'b0, 32'h0040_0010, 1'b0, 21, 8'h77, 1'b1, 1'b1);
        checkVal("mispredict_ignored", 32'(ghr), 32'h0B);

        // Ceiling: entry 7 is driven past 3. Two not-taken steps then leave it at 1.
        for (int i = 0; i < 4; i++) resolveOnly(7, 0, 1'b1, 1'b0);
        resolveOnly(7, 0, 1'b0, 1'b0);
        peek(pcFor(7));
        checkVal("sat_hi_step1", 32'(pred_taken), 32'h1);
        resolveOnly(7, 0, 1'b0, 1'b0);
        peek(pcFor(7));
        checkVal("sat_hi_step2", 32'(pred_taken), 32'h0);

        // Floor: entry 9 is driven below 0. One taken step leaves it at 1.
        for (int i = 0; i < 3; i++) resolveOnly(9, 0, 1'b0, 1'b0);
        resolveOnly(9, 0, 1'b1, 1'b0);
        peek(pcFor(9));
        checkVal("sat_lo", 32'(pred_taken), 32'h0);

        // No bypass: looking up entry 9 while it is updated 1 -> 2 returns the old MSB.
        stepCycle(1'b0, 1'b0, pcFor(9), 1'b1, 9, 0, 1'b1, 1'b0);
        peek(pcFor(9));
        checkVal("post_update_visible", 32'(pred_taken), 32'h1);
        pc_d = pcFor(9); resolve_index = 8'd9; resolve_taken = 1'b0; resolve_en = 1'b1; #1;
        checkVal("no_bypass", 32'(pred_taken), 32'h1);
        @(negedge clk);
        // The stray update above is mirrored into the model.
        phtModel[9] = 1;

`ifdef GSHARE_PRED_STATS_EN
        // Statistics: 5 resolves, 2 of them mispredicted.
        stepCycle(1'b1, 1'b0, 32'h0040_0010, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) resolveOnly(30 + i, 8'h10, 1'b0, (i == 1 || i == 3));
        checkVal("stat_b_five", statBranches, 32'd5);
        checkVal("stat_m_two", statMispredicts, 32'd2);
        stepCycle(1'b1, 1'b1, 32'h0040_0010, 1'b1, 3, 8'hFF, 1'b1, 1'b1);
        checkVal("stat_b_reset", statBranches, 32'd0);
        checkVal("stat_m_reset", statMispredicts, 32'd0);
`endif

        // Randomized traffic with small index ranges to force collisions.
        for (int n = 0; n < 400; n++) begin
            logic        r, pe, re, rt, rm;
            logic [31:0] pc;
            int          ridx;
            r   = ($urandom_range(0, 99) == 0);
            pe  = $urandom_range(0, 1);
            pc  = ($urandom_range(0, 3) == 0) ? $urandom : pcFor($urandom_range(0, 15));
            re  = ($urandom_range(0, 2) != 0);
            ridx = ($urandom_range(0, 3) == 0) ? modelIndex(pc) : int'($urandom_range(0, 15));
            rt  = $urandom_range(0, 1);
            rm  = ($urandom_range(0, 4) == 0);
            stepCycle(r, pe, pc, re, ridx, int'($urandom_range(0, 255)), rt, rm);
        end

        // Reset in the middle of activity discards history and training.
        for (int i = 0; i < 3; i++) resolveOnly(4, 0, 1'b1, 1'b0);
        stepCycle(1'b0, 1'b1, 32'h0040_0010, 1'b0, 0, 0, 1'b0, 1'b0);
        stepCycle(1'b1, 1'b1, 32'h0040_0010, 1'b1, 4, 8'hAB, 1'b1, 1'b1);
        checkVal("midrun_reset_ghr", 32'(ghr), 32'h00);
        peek(32'h0040_0010);
        checkVal("midrun_reset_taken", 32'(pred_taken), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised global-history branch direction predictor for the 5-stage MIPS pipeline.
- Successor to the fixed global-history scheme: configurable history length, PHT depth, counter width and index mode (bimodal / gshare / global-only).
- Adds speculative history update with checkpoint recovery on mispredict.
- Lookup in Decode, alongside branchD; resolve/update from Execute. Pipeline top gates predict_en with branchD and ~stallD.

Parameters:
- IDX_BITS, 8, log2 of PHT entries; PHT has 2^IDX_BITS counters.
- GHR_BITS, 8, global history length. Must satisfy 1 <= GHR_BITS <= IDX_BITS.
- CTR_BITS, 2, saturating counter width (>= 1).
- INDEX_MODE, 1, index function: 0 = bimodal, 1 = gshare, 2 = global-only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- predict_en  in  1  branch in Decode, not stalled; advance speculative GHR
- pc_d  in  32  PC of the Decode-stage instruction
- pred_taken  out  1  predicted direction (combinational)
- pred_index  out  IDX_BITS  PHT index used; carried down the pipe
- pred_ghr  out  GHR_BITS  GHR snapshot before this prediction; carried down the pipe
- resolve_en  in  1  branch resolved this cycle
- resolve_index  in  IDX_BITS  carried pred_index
- resolve_ghr  in  GHR_BITS  carried pred_ghr
- resolve_taken  in  1  actual direction
- resolve_mispredict  in  1  actual direction != predicted direction
- ghr  out  GHR_BITS  current speculative history register

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- On rst:
  - ghr = 0.
  - Every PHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2-bit counters).
  - Optional statistics counters = 0.
  - rst overrides all other inputs in the same cycle. A reset mid-operation discards in-flight history.
- Index: pcx = pc_d[IDX_BITS+1:2]; g = ghr zero-extended to IDX_BITS.
  - Mode 0: pred_index = pcx.
  - Mode 1: pred_index = pcx ^ g.
  - Mode 2: pred_index = g.
- Lookup (zero latency, combinational):
  - pred_taken = MSB of PHT[pred_index].
  - pred_ghr = ghr.
  - Outputs are valid regardless of predict_en.
- Speculative history:
  - When predict_en=1 and no mispredict is resolving, ghr <= {ghr[GHR_BITS-2:0], pred_taken} at the clock edge.
  - When GHR_BITS = 1, ghr <= pred_taken.
- Recovery: when resolve_en=1 and resolve_mispredict=1, ghr <= {resolve_ghr[GHR_BITS-2:0], resolve_taken}.
  - Recovery has priority over a simultaneous predict_en; the younger Decode instruction is flushed by the hazard unit.
- PHT update: when resolve_en=1, PHT[resolve_index] saturates toward resolve_taken.
  - Taken: +1, capped at 2^CTR_BITS-1.
  - Not taken: -1, floored at 0.
  - The update is applied whether or not the branch was mispredicted.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update value (no bypass). The update is visible from the next cycle.
- resolve_mispredict is ignored when resolve_en=0.

Optional Feature:
- Macro: GSHARE_PRED_STATS_EN.
- When defined, adds two outputs:
  - stat_branches, 32 bits: increments on every resolve_en.
  - stat_mispredicts, 32 bits: increments on resolve_en && resolve_mispredict.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined: no such ports or registers exist; all other behaviour is identical.

Test Plan:
- Reset then lookup: pc_d=0x00400010, INDEX_MODE=1, ghr=0 -> pred_index=0x04, pred_taken=0, ghr=0x00.
- Training: two cycles of resolve_en=1, resolve_index=0x04, resolve_taken=1 -> PHT[4] goes 1->2->3; lookup at pc 0x00400010 with ghr=0 then gives pred_taken=1.
- Speculative shift from ghr=0x00:
  - predict_en with pred_taken=1 -> ghr=0x01.
  - Next predict_en with pred_taken=0 -> ghr=0x02.
  - predict_en=0 for one cycle -> ghr holds 0x02.
- Recovery priority: ghr=0xF3, predict_en=1, resolve_en=1, resolve_mispredict=1, resolve_ghr=0x05, resolve_taken=1 -> ghr=0x0B next cycle (predict_en ignored).
- Saturation and no-bypass:
  - PHT[7]=3 plus resolve taken -> stays 3.
  - PHT[9]=0 plus resolve not-taken -> stays 0.
  - Lookup at index 9 in the same cycle as an update to index 9 returns the old MSB.
- Stats (GSHARE_PRED_STATS_EN): 5 resolves, 2 mispredicts -> stat_branches=5, stat_mispredicts=2; rst mid-run -> both 0 and ghr=0 next cycle.
